// File: rtl/uart_mmio_ctrl_if.sv
// Memory-mapped bus between the CPU address decoder (master) and the UART controller (slave).
interface uart_mmio_ctrl_if #(parameter int Width = 32);
  logic             sel;
  logic             memWrite;
  logic             memRead;
  logic [Width-1:0] address;
  logic [Width-1:0] WriteData;
  logic [Width-1:0] ReadData;

  modport master (output sel, memWrite, memRead, address, WriteData, input ReadData);
  modport slave  (input sel, memWrite, memRead, address, WriteData, output ReadData);
endinterface

// File: rtl/uart_mmio_ctrl.sv
// UART MMIO controller: TX/RX byte FIFOs, STATUS/CTRL, TX launch FSM; irq only with UART_IRQ_EN.
// Reads combinational, writes/pops at the edge; full FIFOs drop the byte and raise a sticky overflow.

module uart_mmio_fifo #(parameter int DEPTH = 8) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when an entry leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module uart_mmio_ctrl #(
  parameter int Width      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_mmio_ctrl_if.slave        bus,
  output logic [7:0]             tx_data,
  output logic                   tx_wr_en,
  input  logic                   tx_busy,
  input  logic [7:0]             rx_data,
  input  logic                   rx_ready,
  output logic                   rx_ready_clr,
  output logic                   irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} tx_state_t;
  tx_state_t state, state_nxt;

  logic [1:0]    offset;
  logic          tx_push, tx_pop, rx_take, rx_pop, stat_wr, ctrl_wr;
  logic [7:0]    tx_head, rx_head, tx_last, tx_count8;
  logic          tx_empty, tx_full, rx_empty, rx_full;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf, rx_ovr, tx_active;
  logic          tx_ovf_set, rx_ovr_set;
  logic [1:0]    guard_cnt;
  logic [2:0]    ctrl;
  logic [15:0]   status;
  logic          unused_bits;

  assign offset  = bus.address[3:2];
  assign tx_push = bus.sel && bus.memWrite && (offset == 2'd0);
  assign rx_pop  = bus.sel && bus.memRead  && (offset == 2'd1);
  assign stat_wr = bus.sel && bus.memWrite && (offset == 2'd2);
  assign ctrl_wr = bus.sel && bus.memWrite && (offset == 2'd3);
  assign unused_bits = &{1'b0, bus.WriteData[Width-1:8], bus.address[Width-1:4],
                         bus.address[1:0], rx_count};

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop), .din(bus.WriteData[7:0]),
    .dout(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );

  uart_mmio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_take), .pop(rx_pop), .din(rx_data),
    .dout(rx_head), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );

  // The receiver keeps rx_ready up until it sees our clear, so skip the cycle right after one.
  assign rx_take    = rx_ready && !rx_ready_clr;
  assign tx_pop     = (state == START);
  assign tx_ovf_set = tx_push && tx_full && !tx_pop;
  assign rx_ovr_set = rx_take && rx_full && !rx_pop;
  assign tx_active  = (state != IDLE);
  assign tx_data    = (state == START) ? tx_head : tx_last;
  assign tx_count8  = {{(8-CW){1'b0}}, tx_count};
  assign status     = {tx_count8, 2'b00, tx_ovf, tx_active, rx_ovr, !rx_empty, tx_empty, tx_full};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      guard_cnt    <= '0;
      tx_last      <= '0;
      tx_ovf       <= 1'b0;
      rx_ovr       <= 1'b0;
      rx_ready_clr <= 1'b0;
    end else begin
      state        <= state_nxt;
      guard_cnt    <= (state == WAIT_HI) ? guard_cnt + 1'b1 : 2'd0;
      rx_ready_clr <= rx_take;
      if (state == START) tx_last <= tx_head;
      if (tx_ovf_set)                      tx_ovf <= 1'b1;
      else if (stat_wr && bus.WriteData[5]) tx_ovf <= 1'b0;
      if (rx_ovr_set)                      rx_ovr <= 1'b1;
      else if (stat_wr && bus.WriteData[3]) rx_ovr <= 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_wr_en  = 1'b0;
    case (state)
      IDLE:    if (!tx_empty && !tx_busy) state_nxt = START;
      START: begin
        tx_wr_en  = 1'b1;
        state_nxt = WAIT_HI;
      end
      // Give up on seeing busy after four quiet cycles so a missed pulse cannot hang TX.
      WAIT_HI: if (tx_busy) state_nxt = WAIT_LO;
               else if (guard_cnt == 2'd3) state_nxt = IDLE;
      WAIT_LO: if (!tx_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ReadData = '0;
    if (bus.sel) begin
      case (offset)
        2'd1:    bus.ReadData[7:0]  = rx_empty ? 8'h00 : rx_head;
        2'd2:    bus.ReadData[15:0] = status;
        2'd3:    bus.ReadData[2:0]  = ctrl;
        default: ;
      endcase
    end
  end

`ifdef UART_IRQ_EN
  logic [2:0] ctrl_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl_q <= bus.WriteData[2:0];
      irq_q <= (ctrl_q[0] & !rx_empty) | (ctrl_q[1] & tx_empty & !tx_active) |
               (ctrl_q[2] & (tx_ovf | rx_ovr));
    end
  end

  assign ctrl = ctrl_q;
  assign irq  = irq_q;
`else
  logic unused_ctrl;
  assign unused_ctrl = ctrl_wr;
  assign ctrl = 3'b000;
  assign irq  = 1'b0;
`endif
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with a model UART transmitter and receiver handshake.
module tb_uart_mmio_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_mmio_ctrl_if #(.Width(32)) bus_if ();

  logic [7:0] tx_data, rx_data, rx_drv;
  logic       tx_wr_en, tx_busy, rx_ready, rx_ready_clr, irq;
  logic       hold_busy, model_en, loop_en;
  int         busy_cnt = 0, launches = 0, clr_pulses = 0;
  logic [7:0] launch_log [$];
  int         errors = 0, checks = 0;
  int         base;
  logic [31:0] d;

  uart_mmio_ctrl #(.Width(32), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .tx_data(tx_data), .tx_wr_en(tx_wr_en), .tx_busy(tx_busy),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_ready_clr(rx_ready_clr), .irq(irq)
  );

  assign rx_data = loop_en ? tx_data : rx_drv;
  assign tx_busy = hold_busy | (busy_cnt != 0);

  // Model transmitter: busy rises the cycle after a launch and stays up for 10 cycles.
  always @(posedge clk) begin
    if (tx_wr_en) begin
      launches <= launches + 1;
      launch_log.push_back(tx_data);
    end
    if (tx_wr_en && model_en) busy_cnt <= 10;
    else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
    if (rx_ready_clr) clr_pulses <= clr_pulses + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] off, input logic [7:0] v);
    bus_if.sel = 1'b1; bus_if.memWrite = 1'b1;
    bus_if.address = {28'h0, off, 2'b00}; bus_if.WriteData = {24'h0, v};
    tick();
    bus_if.sel = 1'b0; bus_if.memWrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] off, input logic pop, output logic [31:0] v);
    bus_if.sel = 1'b1; bus_if.memRead = pop; bus_if.address = {28'h0, off, 2'b00};
    #1 v = bus_if.ReadData;
    tick();
    bus_if.sel = 1'b0; bus_if.memRead = 1'b0;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] v;
    bus_rd(off, 1'b0, v);
    check(tag, v, exp);
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_drv = b; rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; hold_busy = 1'b0; model_en = 1'b1; loop_en = 1'b0;
    rx_ready = 1'b0; rx_drv = 8'h00;
    bus_if.sel = 1'b0; bus_if.memWrite = 1'b0; bus_if.memRead = 1'b0;
    bus_if.address = '0; bus_if.WriteData = '0;
    #1;
    check("rst_tx_wr_en", {31'h0, tx_wr_en}, 32'h0);
    check("rst_rx_clr", {31'h0, rx_ready_clr}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick();
    bus_if.address = 32'h8;
    #1 check("sel0_readdata", bus_if.ReadData, 32'h0);
    chk_reg("status_rst", 2'd2, 32'h0002);
    chk_reg("rxdata_rst", 2'd1, 32'h0);
    chk_reg("ctrl_rst", 2'd3, 32'h0);
    chk_reg("txdata_read_zero", 2'd0, 32'h0);

    // Two bytes through the model transmitter.
    bus_wr(2'd0, 8'h41);
    bus_wr(2'd0, 8'h42);
    for (int i = 0; i < 200 && launches < 2; i++) tick();
    check("tx_two_launches", launches, 2);
    tick(20);
    check("tx_no_extra_launch", launches, 2);
    check("tx_first_byte", {24'h0, launch_log[0]}, 32'h41);
    check("tx_second_byte", {24'h0, launch_log[1]}, 32'h42);
    check("tx_data_holds", {24'h0, tx_data}, 32'h42);
    chk_reg("status_tx_done", 2'd2, 32'h0002);

    // Transmitter that never raises busy: the WAIT_HI guard must release the FSM.
    model_en = 1'b0;
    base = launches;
    bus_wr(2'd0, 8'hA5);
    bus_wr(2'd0, 8'h5A);
    tick(30);
    check("guard_launches", launches, base + 2);
    check("guard_second_byte", {24'h0, launch_log[base+1]}, 32'h5A);
    chk_reg("guard_status_idle", 2'd2, 32'h0002);
    model_en = 1'b1;

    // Nine writes with busy held: eight stored, ninth dropped.
    hold_busy = 1'b1;
    for (int i = 0; i < 9; i++) bus_wr(2'd0, 8'(i));
    chk_reg("tx_full_ovf", 2'd2, 32'h0821);
    bus_wr(2'd2, 8'h20);
    chk_reg("tx_ovf_cleared", 2'd2, 32'h0801);
    bus_wr(2'd1, 8'hFF);
    chk_reg("rxdata_write_ignored", 2'd2, 32'h0801);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; hold_busy = 1'b0;
    tick(15);
    chk_reg("status_after_flush", 2'd2, 32'h0002);

    // Reset in WAIT_LO with three bytes queued.
    bus_wr(2'd0, 8'h31);
    bus_wr(2'd0, 8'h32);
    bus_wr(2'd0, 8'h33);
    bus_wr(2'd0, 8'h34);
    tick(4);
    chk_reg("wait_lo_status", 2'd2, 32'h0310);
    base = launches;
    rst_n = 1'b0;
    bus_if.sel = 1'b1; bus_if.address = 32'h8;
    #1;
    check("midrst_tx_wr_en", {31'h0, tx_wr_en}, 32'h0);
    check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
    check("midrst_status", bus_if.ReadData, 32'h0002);
    bus_if.sel = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(40);
    check("no_launch_after_rst", launches, base);

    // Loopback of 0x55 into the receiver.
    loop_en = 1'b1;
    base = launches;
    bus_wr(2'd0, 8'h55);
    for (int i = 0; i < 50 && launches == base; i++) tick();
    check("loop_launch", launches, base + 1);
    base = clr_pulses;
    rx_ready = 1'b1;
    for (int i = 0; i < 10 && !rx_ready_clr; i++) tick();
    check("loop_clr_seen", {31'h0, rx_ready_clr}, 32'h1);
    tick();
    rx_ready = 1'b0;
    tick(3);
    check("loop_clr_once", clr_pulses, base + 1);
    bus_rd(2'd2, 1'b0, d);
    check("loop_rx_nonempty", {31'h0, d[2]}, 32'h1);
    bus_rd(2'd1, 1'b1, d);
    check("loop_rxdata", d, 32'h55);
    chk_reg("loop_rx_after_pop", 2'd1, 32'h0);
    bus_rd(2'd2, 1'b0, d);
    check("loop_rx_empty", {31'h0, d[2]}, 32'h0);
    loop_en = 1'b0;
    tick(20);

    // Nine received bytes, no pops.
    for (int i = 0; i < 9; i++) send_rx(8'h10 + 8'(i));
    chk_reg("rx_ovr_status", 2'd2, 32'h000E);
    for (int i = 0; i < 8; i++) begin
      bus_rd(2'd1, 1'b1, d);
      check($sformatf("rx_order%0d", i), d, 32'h10 + i);
    end
    chk_reg("rx_drained", 2'd1, 32'h0);
    bus_wr(2'd2, 8'h08);
    chk_reg("rx_ovr_cleared", 2'd2, 32'h0002);

    // Full RX FIFO popped while a new byte arrives.
    for (int i = 0; i < 8; i++) send_rx(8'h20 + 8'(i));
    rx_drv = 8'h99; rx_ready = 1'b1;
    bus_if.sel = 1'b1; bus_if.memRead = 1'b1; bus_if.address = 32'h4;
    #1 check("full_pop_head", bus_if.ReadData, 32'h20);
    tick();
    bus_if.sel = 1'b0; bus_if.memRead = 1'b0; rx_ready = 1'b0;
    tick();
    chk_reg("full_pop_no_ovr", 2'd2, 32'h0006);
    for (int i = 0; i < 7; i++) begin
      bus_rd(2'd1, 1'b1, d);
      check($sformatf("full_pop_order%0d", i), d, 32'h21 + i);
    end
    bus_rd(2'd1, 1'b1, d);
    check("full_pop_new_byte", d, 32'h99);

`ifdef UART_IRQ_EN
    bus_wr(2'd3, 8'h01);
    chk_reg("ctrl_readback", 2'd3, 32'h1);
    check("irq_idle", {31'h0, irq}, 32'h0);
    rx_drv = 8'h77; rx_ready = 1'b1;
    tick();
    check("irq_latency", {31'h0, irq}, 32'h0);
    rx_ready = 1'b0;
    tick();
    check("irq_set", {31'h0, irq}, 32'h1);
    bus_rd(2'd1, 1'b1, d);
    check("irq_pop_data", d, 32'h77);
    tick();
    check("irq_cleared", {31'h0, irq}, 32'h0);
    bus_wr(2'd3, 8'h00);
`else
    bus_wr(2'd3, 8'h07);
    chk_reg("ctrl_reads_zero", 2'd3, 32'h0);
    send_rx(8'h77);
    tick(3);
    check("irq_stays_low", {31'h0, irq}, 32'h0);
    bus_rd(2'd1, 1'b1, d);
    check("irq_pop_data", d, 32'h77);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_mmio_ctrl.md
UART_MMIO_CTRL -- requirements
Module: uart_mmio_ctrl

Interface
REQ-001 Parameter Width, default 32: bus data and address width.
REQ-002 Parameter FIFO_DEPTH, default 8: TX and RX FIFO depth in bytes; power of 2 only, minimum 2.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 sel  input  1  chip select from the address decoder; high when the address falls in the UART window.
REQ-006 memWrite  input  1  bus write strobe; acts only when sel=1.
REQ-007 memRead  input  1  bus read strobe; acts only when sel=1.
REQ-008 address  input  Width  byte address; only bits [3:2] are decoded (offset).
REQ-009 WriteData  input  Width  write data; only bits [7:0] are used.
REQ-010 ReadData  output  Width  combinational read data; zero-extended.
REQ-011 tx_data  output  8  byte presented to the UART transmitter.
REQ-012 tx_wr_en  output  1  one-cycle start pulse to the transmitter.
REQ-013 tx_busy  input  1  transmitter busy flag.
REQ-014 rx_data  input  8  received byte from the UART receiver.
REQ-015 rx_ready  input  1  receiver byte-available flag; level, held until cleared.
REQ-016 rx_ready_clr  output  1  one-cycle clear pulse to the receiver.
REQ-017 irq  output  1  interrupt request, active-high level.

Function
REQ-018 The register map SHALL be: offset 0 TXDATA (write), 1 RXDATA (read), 2 STATUS (read, write-1-to-clear), 3 CTRL (read/write).
REQ-019 A write to TXDATA SHALL push WriteData[7:0] into the TX FIFO on the clock edge; if the TX FIFO is full, it SHALL drop the byte and set sticky tx_ovf.
REQ-020 ReadData for RXDATA SHALL be the RX FIFO head, or 0 when the RX FIFO is empty; a read with memRead=1 SHALL pop one entry on the clock edge; a pop while empty SHALL have no effect.
REQ-021 STATUS SHALL read {tx_count[7:0] at bits[15:8], 0 at bits[7:6], tx_ovf at bit 5, tx_active at bit 4, rx_ovr at bit 3, rx_nonempty at bit 2, tx_empty at bit 1, tx_full at bit 0}.
REQ-022 A STATUS write SHALL clear tx_ovf where WriteData[5]=1 and rx_ovr where WriteData[3]=1; if a new set event occurs in the same cycle, set SHALL win.
REQ-023 Reads and writes to offsets not listed SHALL return 0 and have no effect; ReadData SHALL be 0 when sel=0.
REQ-024 The TX FSM SHALL use states IDLE, START, WAIT_HI, WAIT_LO.
REQ-025 IDLE->START when the TX FIFO is non-empty and tx_busy=0; START drives tx_wr_en=1 for exactly one cycle with tx_data=FIFO head, pops the FIFO, and then goes ->WAIT_HI.
REQ-026 WAIT_HI->WAIT_LO when tx_busy=1; WAIT_HI->IDLE after 4 cycles with tx_busy=0 (missed-busy guard); WAIT_LO->IDLE when tx_busy=0. tx_active=1 in any state other than IDLE.
REQ-027 tx_data SHALL hold the last launched byte in all states other than START.
REQ-028 When rx_ready=1 and rx_ready_clr was not asserted in the previous cycle, the block SHALL pulse rx_ready_clr for one cycle and push rx_data if the RX FIFO is not full; otherwise it SHALL drop the byte and set rx_ovr.
REQ-029 A simultaneous push and pop on either FIFO SHALL both take effect with the count unchanged; a full RX FIFO popped in the same cycle SHALL accept the push without setting rx_ovr.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; counts SHALL range 0..FIFO_DEPTH.

Reset
REQ-031 rst_n=0 SHALL immediately force: FSM=IDLE; both FIFOs empty; tx_ovf=0; rx_ovr=0; CTRL=0; tx_data=0; tx_wr_en=0; rx_ready_clr=0; irq=0.
REQ-032 Reset during a transmission SHALL abandon the in-flight byte and discard queued TX data; no tx_wr_en SHALL be issued until at least one cycle after rst_n rises.

Configuration
REQ-033 With UART_IRQ_EN defined: CTRL[0]=rx interrupt enable, CTRL[1]=tx-empty interrupt enable, CTRL[2]=error interrupt enable; irq=(CTRL[0]&rx_nonempty)|(CTRL[1]&tx_empty&!tx_active)|(CTRL[2]&(tx_ovf|rx_ovr)), registered (1-cycle latency).
REQ-034 Without UART_IRQ_EN: CTRL SHALL read 0, CTRL writes SHALL be ignored, and irq SHALL be constant 0.

Verification
REQ-035 Write 0x41, 0x42 to TXDATA with a model UART (busy 10 cycles, 1 cycle after wr_en) -> two tx_wr_en pulses, tx_data 0x41 then 0x42, and STATUS reads 0x0002 when done.
REQ-036 9 TXDATA writes while tx_busy is held at 1 -> tx_count=8, tx_full=1, tx_ovf=1; write STATUS 0x20 -> tx_ovf=0.
REQ-037 Loop tx_data back into rx_data with rx_ready=1 and send 0x55 -> rx_ready_clr pulses once, RXDATA reads 0x55, and after the pop RXDATA reads 0 with rx_nonempty=0.
REQ-038 Assert rx_ready 9 times with no pops -> the 9th byte is dropped, rx_ovr=1, and 8 bytes are read back in order.
REQ-039 Assert rst_n=0 in WAIT_LO with 3 bytes queued -> outputs are reset immediately and no tx_wr_en occurs after release.
REQ-040 With UART_IRQ_EN, CTRL=0x1 and one byte received -> irq=1 one cycle later; irq=0 after RXDATA pop. Without UART_IRQ_EN, irq stays 0.
